// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
//   UART_PACKET : one byte of a packet stream plus its framing and routing fields
//   DEST_*      : destination codes carried in UART_PACKET.Destination
//   arbState_t  : arbiter state encoding
package uart_tx_arbiter_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    localparam logic [7:0] DEST_REG_WRITE     = 8'h00;
    localparam logic [7:0] DEST_READ_RESPONSE = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting one position after `last`, wrapping
// around, and reports the first set bit.
//   request : one bit per requester
//   last    : index of the previous winner
//   valid   : at least one request is set
//   winner  : chosen index (0 when valid is low)
module rr_pick #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] request,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] winner
);

    always_comb begin
        int sum;
        logic [W-1:0] idx;
        sum    = 0;
        idx    = '0;
        valid  = 1'b0;
        winner = '0;
        for (int i = 1; i <= N; i++) begin
            sum = int'(last) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = W'(sum);
            if (!valid && request[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the UART transmitter.
// One requester is granted per packet; its bytes pass straight through to the
// transmitter and the grant is held until its EoP byte is accepted.
//
// Ports:
//   ipClk, ipnReset  : clock, asynchronous active-low reset
//   ipReqStream      : per-requester packet streams
//   opReqReady       : per-requester ready
//   opTxStream       : stream to the transmitter
//   ipTxReady        : transmitter ready
//   opGrant          : current / most recent grantee
//   opBusy           : high in ARB and BUSY
//   opProtocolError  : one-cycle pulse after a drained stray byte or a watchdog release
//
// Build option: define UART_TX_ARB_WATCHDOG_EN to release a grant after
// WATCHDOG_CYCLES consecutive BUSY cycles without a transfer.
//
// state | meaning
// IDLE  | no packet in flight; stray bytes drained
// ARB   | SoP seen; picking the next grantee; stray bytes drained
// BUSY  | grantee's bytes forwarded until EoP is accepted
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
    parameter  int N_PORTS         = 2,
    parameter  int WATCHDOG_CYCLES = 1024,
    localparam int GW              = $clog2(N_PORTS)
) (
    input  logic               ipClk,
    input  logic               ipnReset,
    input  UART_PACKET         ipReqStream [N_PORTS],
    output logic [N_PORTS-1:0] opReqReady,
    output UART_PACKET         opTxStream,
    input  logic               ipTxReady,
    output logic [GW-1:0]      opGrant,
    output logic               opBusy,
    output logic               opProtocolError
);

    arbState_t          state;
    arbState_t          nextState;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      lastGrant;
    logic [N_PORTS-1:0] sopReq;
    logic [N_PORTS-1:0] strayReq;
    logic               pickValid;
    logic [GW-1:0]      pickWinner;
    UART_PACKET         grantPkt;
    logic               transfer;
    logic               wdExpire;
    logic               errNext;
    logic               protocolError;

    always_comb begin
        sopReq   = '0;
        strayReq = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            sopReq[p]   = ipReqStream[p].Valid &&  ipReqStream[p].SoP;
            strayReq[p] = ipReqStream[p].Valid && !ipReqStream[p].SoP;
        end
    end

    rr_pick #(.N(N_PORTS)) uPick (
        .request (sopReq),
        .last    (lastGrant),
        .valid   (pickValid),
        .winner  (pickWinner)
    );

    assign grantPkt = ipReqStream[grant];
    assign transfer = (state == BUSY) && grantPkt.Valid && ipTxReady;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WDW-1:0] wdCount;

    // Expires on the stall cycle that would bring the count to WATCHDOG_CYCLES.
    assign wdExpire = (state == BUSY) && !transfer &&
                      (wdCount == WDW'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            wdCount <= '0;
        end else if ((state != BUSY) || transfer || wdExpire) begin
            wdCount <= '0;
        end else begin
            wdCount <= wdCount + WDW'(1);
        end
    end
`else
    logic unusedWatchdogCfg;
    assign wdExpire          = 1'b0;
    assign unusedWatchdogCfg = (WATCHDOG_CYCLES > 0);
`endif

    always_comb begin
        nextState  = state;
        opReqReady = '0;
        opTxStream = '0;
        errNext    = 1'b0;
        case (state)
            IDLE: begin
                if (|sopReq) begin
                    nextState = ARB;
                end
            end
            ARB: begin
                nextState = pickValid ? BUSY : IDLE;
            end
            BUSY: begin
                opTxStream        = grantPkt;
                opReqReady[grant] = ipTxReady;
                if (transfer && grantPkt.EoP) begin
                    nextState = IDLE;
                end else if (wdExpire) begin
                    nextState = IDLE;
                    errNext   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
        // Stray bytes are drained outside BUSY; gated by reset so every ready
        // reads zero while reset is held.
        if ((state != BUSY) && ipnReset) begin
            opReqReady = strayReq;
            errNext    = |strayReq;
        end
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state         <= IDLE;
            grant         <= '0;
            lastGrant     <= GW'(N_PORTS - 1);
            protocolError <= 1'b0;
        end else begin
            state         <= nextState;
            protocolError <= errNext;
            if ((state == ARB) && pickValid) begin
                grant     <= pickWinner;
                lastGrant <= pickWinner;
            end
        end
    end

    assign opGrant         = grant;
    assign opBusy          = (state != IDLE);
    assign opProtocolError = protocolError;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NP = 2;

    logic          ipClk = 1'b0;
    logic          ipnReset = 1'b0;
    UART_PACKET    reqStream [NP];
    logic [NP-1:0] reqReady;
    UART_PACKET    txStream;
    logic          ipTxReady = 1'b1;
    logic [0:0]    grantOut;
    logic          busyOut;
    logic          protoErr;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] expData [$];
    int         expGrant [$];

    uart_tx_arbiter #(.N_PORTS(NP), .WATCHDOG_CYCLES(16)) dut (
        .ipClk           (ipClk),
        .ipnReset        (ipnReset),
        .ipReqStream     (reqStream),
        .opReqReady      (reqReady),
        .opTxStream      (txStream),
        .ipTxReady       (ipTxReady),
        .opGrant         (grantOut),
        .opBusy          (busyOut),
        .opProtocolError (protoErr)
    );

    always #5 ipClk = ~ipClk;

    initial begin
        #500000;
        $display("FAIL globalTimeout: simulation did not finish");
        $fatal(1);
    end

    // {inputs per port as {valid,sop,eop}, data}, txReady, expected outputs
    typedef struct packed {
        logic [2:0] p0;
        logic [7:0] d0;
        logic [2:0] p1;
        logic [7:0] d1;
        logic       txr;
        logic       eBusy;
        logic       eGrant;
        logic [1:0] eRdy;
        logic       eTxV;
        logic [7:0] eTxD;
        logic       eErr;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mkVec(input logic [2:0] p0, input logic [7:0] d0,
                                   input logic [2:0] p1, input logic [7:0] d1,
                                   input logic txr, input logic eBusy, input logic eGrant,
                                   input logic [1:0] eRdy, input logic eTxV,
                                   input logic [7:0] eTxD, input logic eErr);
        vec_t v;
        v.p0 = p0; v.d0 = d0; v.p1 = p1; v.d1 = d1; v.txr = txr;
        v.eBusy = eBusy; v.eGrant = eGrant; v.eRdy = eRdy;
        v.eTxV = eTxV; v.eTxD = eTxD; v.eErr = eErr;
        return v;
    endfunction

    function automatic UART_PACKET mkPkt(input int src, input logic [7:0] data,
                                         input logic sop, input logic eop, input logic valid);
        UART_PACKET p;
        p.Source      = 8'(src);
        p.Destination = DEST_READ_RESPONSE;
        p.Length      = 8'd4;
        p.Data        = data;
        p.SoP         = sop;
        p.EoP         = eop;
        p.Valid       = valid;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic idleAll();
        for (int p = 0; p < NP; p++) reqStream[p] = '0;
    endtask

    task automatic doReset();
        @(negedge ipClk);
        ipnReset  = 1'b0;
        ipTxReady = 1'b1;
        idleAll();
        #2;
        check("resetValues", {busyOut, grantOut, protoErr, reqReady, (txStream != '0)}, 32'h0);
        @(negedge ipClk);
        ipnReset = 1'b1;
    endtask

    // Drives full packets on the requested ports and logs what reaches the transmitter.
    task automatic runPackets(input int pkts0, input int pkts1, input int len, input int budget,
                              input string tag);
        int idx [NP];
        int pktNo [NP];
        int pkts [NP];
        logic [7:0] gotData [$];
        int gotGrant [$];
        logic done;
        pkts[0] = pkts0; pkts[1] = pkts1;
        for (int p = 0; p < NP; p++) begin idx[p] = 0; pktNo[p] = 0; end
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge ipClk); #1;
            ipTxReady = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (pktNo[p] < pkts[p])
                    reqStream[p] = mkPkt(p, 8'(p * 64 + pktNo[p] * 8 + idx[p]),
                                         idx[p] == 0, idx[p] == len - 1, 1'b1);
                else
                    reqStream[p] = '0;
            end
            @(negedge ipClk);
            if (txStream.Valid && ipTxReady) begin
                gotData.push_back(txStream.Data);
                if (txStream.SoP) gotGrant.push_back(int'(grantOut));
            end
            for (int p = 0; p < NP; p++) begin
                if (reqStream[p].Valid && reqReady[p]) begin
                    idx[p]++;
                    if (idx[p] == len) begin idx[p] = 0; pktNo[p]++; end
                end
            end
            done = (pktNo[0] >= pkts[0]) && (pktNo[1] >= pkts[1]);
        end
        @(posedge ipClk); #1;
        idleAll();
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_byteCount"}, gotData.size(), expData.size());
        for (int i = 0; i < expData.size() && i < gotData.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(gotData[i]), 32'(expData[i]));
        check({tag, "_pktCount"}, gotGrant.size(), expGrant.size());
        for (int i = 0; i < expGrant.size() && i < gotGrant.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), gotGrant[i], expGrant[i]);
    endtask

    initial begin
        int stall;
        idleAll();
        ipTxReady = 1'b1;

        //            p0     d0     p1     d1    txr busy g  rdy   txv  txd    err
        vecs[0]  = mkVec(3'b110, 8'hA0, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        vecs[1]  = mkVec(3'b110, 8'hA0, 3'b000, 8'h00, 1, 1, 0, 2'b00, 0, 8'h00, 0);
        vecs[2]  = mkVec(3'b110, 8'hA0, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hA0, 0);
        vecs[3]  = mkVec(3'b100, 8'hA1, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hA1, 0);
        vecs[4]  = mkVec(3'b100, 8'hA2, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hA2, 0);
        vecs[5]  = mkVec(3'b101, 8'hA3, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hA3, 0);
        vecs[6]  = mkVec(3'b000, 8'h00, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        vecs[7]  = mkVec(3'b110, 8'hB0, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        vecs[8]  = mkVec(3'b110, 8'hB0, 3'b000, 8'h00, 1, 1, 0, 2'b00, 0, 8'h00, 0);
        vecs[9]  = mkVec(3'b110, 8'hB0, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hB0, 0);
        vecs[10] = mkVec(3'b100, 8'hB1, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hB1, 0);
        for (int i = 11; i <= 15; i++)
            vecs[i] = mkVec(3'b100, 8'hB2, 3'b000, 8'h00, 0, 1, 0, 2'b00, 1, 8'hB2, 0);
        vecs[16] = mkVec(3'b100, 8'hB2, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hB2, 0);
        vecs[17] = mkVec(3'b101, 8'hB3, 3'b000, 8'h00, 1, 1, 0, 2'b01, 1, 8'hB3, 0);
        vecs[18] = mkVec(3'b000, 8'h00, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        vecs[19] = mkVec(3'b000, 8'h00, 3'b100, 8'h55, 1, 0, 0, 2'b10, 0, 8'h00, 0);
        vecs[20] = mkVec(3'b000, 8'h00, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 1);
        vecs[21] = mkVec(3'b000, 8'h00, 3'b000, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);

        // Single packet, backpressure stall, stray-byte drain.
        doReset();
        for (int i = 0; i < 22; i++) begin
            @(posedge ipClk); #1;
            reqStream[0] = mkPkt(0, vecs[i].d0, vecs[i].p0[1], vecs[i].p0[0], vecs[i].p0[2]);
            reqStream[1] = mkPkt(1, vecs[i].d1, vecs[i].p1[1], vecs[i].p1[0], vecs[i].p1[2]);
            ipTxReady    = vecs[i].txr;
            @(negedge ipClk);
            check($sformatf("vec%0d", i),
                  {busyOut, grantOut, reqReady, txStream.Valid, txStream.Data, protoErr},
                  {vecs[i].eBusy, vecs[i].eGrant, vecs[i].eRdy, vecs[i].eTxV, vecs[i].eTxD, vecs[i].eErr});
        end
        @(posedge ipClk); #1;
        idleAll();

        // Two ports contending continuously: grants alternate 0,1,0,1.
        doReset();
        expData.delete(); expGrant.delete();
        for (int k = 0; k < 4; k++) begin
            expGrant.push_back(k % 2);
            for (int i = 0; i < 3; i++) expData.push_back(8'((k % 2) * 64 + (k / 2) * 8 + i));
        end
        runPackets(2, 2, 3, 200, "rr");

        // Reset asserted mid-packet, then a normal packet on port 0.
        doReset();
        @(posedge ipClk); #1;
        reqStream[0] = mkPkt(0, 8'hC0, 1'b1, 1'b0, 1'b1);
        @(posedge ipClk); #1;
        @(posedge ipClk); #1;
        @(posedge ipClk); #1;
        reqStream[0] = mkPkt(0, 8'hC1, 1'b0, 1'b0, 1'b1);
        @(posedge ipClk); #1;
        reqStream[0] = mkPkt(0, 8'hC2, 1'b0, 1'b0, 1'b1);
        @(negedge ipClk);
        check("preResetByte2", {busyOut, txStream.Valid, txStream.Data, reqReady}, {1'b1, 1'b1, 8'hC2, 2'b01});
        #2;
        ipnReset = 1'b0;
        #1;
        check("midPacketReset", {busyOut, grantOut, protoErr, reqReady, (txStream != '0)}, 32'h0);
        @(negedge ipClk);
        idleAll();
        ipnReset = 1'b1;
        expData.delete(); expGrant.delete();
        expGrant.push_back(0);
        for (int i = 0; i < 4; i++) expData.push_back(8'(i));
        runPackets(1, 0, 4, 50, "afterReset");

`ifdef UART_TX_ARB_WATCHDOG_EN
        // Grantee stalls after its SoP byte; watchdog releases the grant.
        doReset();
        @(posedge ipClk); #1;
        reqStream[0] = mkPkt(0, 8'hD0, 1'b1, 1'b0, 1'b1);
        reqStream[1] = mkPkt(1, 8'hE0, 1'b1, 1'b1, 1'b1);
        @(posedge ipClk); #1;
        @(posedge ipClk); #1;
        @(negedge ipClk);
        check("wdFirstGrant", {grantOut, reqReady, txStream.Data}, {1'b0, 2'b01, 8'hD0});
        @(posedge ipClk); #1;
        reqStream[0] = '0;
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ipClk);
            if (!busyOut) break;
            stall++;
            @(posedge ipClk);
        end
        check("wdStallCycles", stall, 16);
        check("wdErrorPulse", 32'(protoErr), 32'h1);
        @(posedge ipClk); @(negedge ipClk);
        @(posedge ipClk); @(negedge ipClk);
        check("wdNextGrant", {busyOut, grantOut, txStream.Valid, txStream.Data}, {1'b1, 1'b1, 1'b1, 8'hE0});
        @(posedge ipClk); #1;
        idleAll();
`endif

        repeat (2) @(posedge ipClk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
